// File: rtl/fir_out_round.sv
// FIR output stage: realigns the sample strobe with the last-tap accumulator,
// applies convergent rounding and signed saturation, and buffers results on a valid/ready port.
module fir_out_round #(
   parameter int IW    = 40,
   parameter int OW    = 16,
   parameter int SHIFT = 15,
   parameter int LAT   = 4
) (
   input  logic          i_clk,
   input  logic          reset,
   input  logic          i_ce,
   input  logic [IW-1:0] i_acc,
   output logic [OW-1:0] o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_ovf,
   input  logic          i_ovf_clr,
   output logic          o_drop
);

   localparam int QW = IW - SHIFT + 1;
   localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
   localparam longint MAXL = (longint'(1) << (OW - 1)) - 1;
   localparam logic signed [QW-1:0] MAXV = QW'(MAXL);
   localparam logic signed [QW-1:0] MINV = QW'(-MAXL - 1);
   localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} buf_state_t;

   logic [LAT-1:0]         r_ceSr;
   logic                   w_tap;
   logic signed [QW-1:0]   w_q;
   logic signed [QW-1:0]   w_round;
   logic [SHIFT-1:0]       w_frac;
   logic                   w_inc;
   logic                   r_s1Valid;
   logic signed [QW-1:0]   r_s1Round;
   logic                   w_satHi;
   logic                   w_satLo;
   logic [OW-1:0]          w_satData;
   logic                   r_s2Valid;
   logic [OW-1:0]          r_s2Data;
   logic                   r_ovf;
   buf_state_t             r_state;
   buf_state_t             w_stateNext;
   logic [OW-1:0]          r_head;
   logic [OW-1:0]          r_tail;
   logic [OW-1:0]          w_headNext;
   logic [OW-1:0]          w_tailNext;
   logic                   r_drop;
   logic                   w_dropNext;
   logic                   w_push;
   logic                   w_pop;

   // Strobe delay line: its last tap marks the cycle the matching accumulator is valid
   generate
      if (LAT == 1) begin : g_lat1
         always_ff @(posedge i_clk) begin
            if (reset) r_ceSr <= '0;
            else       r_ceSr <= i_ce;
         end
      end else begin : g_latN
         always_ff @(posedge i_clk) begin
            if (reset) r_ceSr <= '0;
            else       r_ceSr <= {r_ceSr[LAT-2:0], i_ce};
         end
      end
   endgenerate

   assign w_tap = r_ceSr[LAT-1];

   // One extra integer bit keeps the round-up increment from wrapping
   assign w_q     = {i_acc[IW-1], i_acc[IW-1:SHIFT]};
   assign w_frac  = i_acc[SHIFT-1:0];
   assign w_inc   = (w_frac > HALF) || ((w_frac == HALF) && w_q[0]);
   assign w_round = w_q + QW'(w_inc);

   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_s1Valid <= 1'b0;
         r_s1Round <= '0;
      end else begin
         r_s1Valid <= w_tap;
         if (w_tap) r_s1Round <= w_round;
      end
   end

   assign w_satHi   = (r_s1Round > MAXV);
   assign w_satLo   = (r_s1Round < MINV);
   assign w_satData = w_satHi ? OMAX : (w_satLo ? OMIN : r_s1Round[OW-1:0]);

   // A new saturation takes priority over a clear in the same cycle
   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_s2Valid <= 1'b0;
         r_s2Data  <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) r_s2Data <= w_satData;
         if (r_s1Valid && (w_satHi || w_satLo)) r_ovf <= 1'b1;
         else if (i_ovf_clr)                    r_ovf <= 1'b0;
      end
   end

   assign w_push = r_s2Valid;
   assign w_pop  = o_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
         r_drop  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_head  <= w_headNext;
         r_tail  <= w_tailNext;
         r_drop  <= w_dropNext;
      end
   end

   // Head register drives o_data directly; a write into an empty buffer shows up next cycle
   always_comb begin
      w_stateNext = r_state;
      w_headNext  = r_head;
      w_tailNext  = r_tail;
      w_dropNext  = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_headNext  = r_s2Data;
               w_stateNext = S_ONE;
            end
         end
         S_ONE: begin
            if (w_push && w_pop) begin
               w_headNext = r_s2Data;
            end else if (w_push) begin
               w_tailNext  = r_s2Data;
               w_stateNext = S_FULL;
            end else if (w_pop) begin
               w_stateNext = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_push && w_pop) begin
               w_headNext = r_tail;
               w_tailNext = r_s2Data;
            end else if (w_push) begin
               w_dropNext = 1'b1;
            end else if (w_pop) begin
               w_headNext  = r_tail;
               w_stateNext = S_ONE;
            end
         end
         default: w_stateNext = S_EMPTY;
      endcase
   end

   assign o_data  = r_head;
   assign o_valid = (r_state != S_EMPTY);
   assign o_ovf   = r_ovf;
   assign o_drop  = r_drop;

endmodule

// File: doc/fir_out_round.md
Name: fir_out_round

Overview:
- Output stage directly downstream of the FIR tap chain.
- Aligns the strobe of each sample entering the chain with the accumulator emerging from the last tap.
- Applies convergent rounding and signed saturation to the wide accumulator, then presents results on a valid/ready interface through a 2-entry buffer.
- Reports overflow (sticky) and dropped samples.

Parameters:
- IW, 40, accumulator width from the last tap's output (signed).
- OW, 16, output sample width (signed).
- SHIFT, 15, fractional bits discarded (coefficient Q format). Constraints: SHIFT >= 1 and SHIFT + OW <= IW.
- LAT, 4, cycles from i_ce to a valid i_acc at the chain output. Constraint: LAT >= 1.

Ports:
- i_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_ce  in  1  sample strobe, asserted in the same cycle the sample is presented to the first tap.
- i_acc  in  IW  signed accumulator from the last tap.
- o_data  out  OW  rounded, saturated sample (buffer head).
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_ovf  out  1  sticky saturation flag.
- i_ovf_clr  in  1  clears o_ovf.
- o_drop  out  1  one-cycle pulse: a result was discarded because the buffer was full.

Behaviour:
- Reset (synchronous, active-high, on i_clk):
  - Clears the LAT-deep strobe shift register, both pipeline stage valids, the buffer (count 0) and o_ovf.
  - o_data=0, o_valid=0, o_ovf=0, o_drop=0.
  - Reset mid-stream discards every in-flight and buffered result. No stale o_valid after reset deasserts.
- Alignment:
  - i_ce enters a LAT-stage shift register.
  - Its tap is high in cycle c+LAT for an i_ce in cycle c; i_acc is captured only in that cycle.
  - i_ce may be asserted every cycle; each strobe yields exactly one result.
- Stage 1, registered at the end of cycle c+LAT (convergent rounding):
  - q = i_acc >>> SHIFT (arithmetic), width IW-SHIFT+1.
  - f = i_acc[SHIFT-1:0]; h = 1 << (SHIFT-1).
  - r = q+1 if f > h, or if f == h and q[0] == 1; otherwise r = q.
  - r is computed in IW-SHIFT+1 bits, so no wrap occurs.
- Stage 2, registered at the end of cycle c+LAT+1 (saturation):
  - r > 2^(OW-1)-1 gives 2^(OW-1)-1; r < -2^(OW-1) gives -2^(OW-1); otherwise r is truncated to OW bits.
  - Saturation sets o_ovf in the same cycle the stage-2 result is registered.
  - If i_ovf_clr and a new saturation occur in the same cycle, set wins.
  - i_ovf_clr alone clears o_ovf on the next edge.
- Buffer:
  - 2-entry FIFO with registered outputs, written by a stage-2 valid result.
  - With the buffer empty, o_valid rises in cycle c+LAT+3 with o_data = the result. Total latency is LAT+3 cycles from i_ce.
  - A pop occurs on o_valid && i_ready.
  - Order is strictly preserved.
  - o_data holds its value while o_valid && !i_ready.
  - o_data is don't-care when o_valid=0 and retains its last value.
- Buffer boundary cases:
  - Full and a write arrives with no pop in the same cycle: the new result is discarded, buffer contents are unchanged, and o_drop pulses for 1 cycle.
  - Full with a pop and a write in the same cycle: the write is accepted, o_drop stays 0, count stays 2.
  - Empty with a write: no same-cycle bypass to o_data; o_valid rises on the next cycle.
  - Count is never above 2 or below 0.
  - A pop on an empty buffer is ignored (o_valid=0).
- No backpressure reaches the tap chain. Sustained rate is 1 result/cycle while i_ready=1.

Test Plan:
- Defaults (IW=40, OW=16, SHIFT=15, LAT=4). i_ce at cycle 0 with i_acc=3<<15 in cycle 4, i_ready=1 -> o_valid=1, o_data=3 in cycle 7, for exactly one cycle.
- Rounding, one sample each, i_acc values:
  - 5<<14 (2.5) -> 2.
  - 7<<14 (3.5) -> 4.
  - (5<<14)+1 -> 3.
  - -(5<<14) -> -2.
  - -(7<<14) -> -4.
  - (5<<14)-1 -> 2.
- Saturation: i_acc=40000<<15 -> 32767 with o_ovf=1. Then -40000<<15 -> -32768. o_ovf stays 1 through subsequent normal samples until i_ovf_clr; clears one cycle later. i_ovf_clr coincident with saturation -> o_ovf stays 1.
- Backpressure: i_ready=0, three consecutive i_ce with values 1, 2, 3 -> o_valid=1 and o_data=1 held; third result dropped, o_drop pulses once. Raise i_ready -> outputs 1 then 2 on consecutive cycles, then o_valid=0.
- Full buffer with pop and write in the same cycle -> no o_drop; output sequence is continuous and in order.
- Back-to-back i_ce for 20 cycles with i_ready=1 -> 20 results in order at 1/cycle.
- Reset asserted at cycle 2 after i_ce at 0 and 1 -> no o_valid afterwards; o_data=0, o_ovf=0.
